// File: rtl/seq_decoder_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
// Holds the FSM encoding, mode constants and the decode function.
package seq_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIRECT,
      SCAN
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   function automatic logic [63:0] onehot(
      input logic [5:0] idx,
      input int         width
   );
      logic [63:0] v;
      v = '0;
      if (int'(idx) < width) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/seq_decoder_dwell.sv
// Dwell counter for SCAN mode; pulses step on the last dwell cycle.
// With DWELL=1 the counter never leaves 0 and step follows run.
module seq_decoder_dwell #(
   parameter int DWELL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic step
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;
   logic             last;

   assign last = (cnt == LAST);
   assign step = run & last;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= last ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_decoder.sv
// Registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
// out is decode(idx) gated by active, optionally inverted.
module seq_decoder
   import seq_decoder_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int DWELL      = 1,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  dir,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  sel_valid,
   output logic [(1<<SEL_W)-1:0] out,
   output logic [SEL_W-1:0]      idx,
   output logic                  active,
   output logic                  wrap
);

   localparam int OUT_W = 1 << SEL_W;
   localparam logic [OUT_W-1:0] POL = {OUT_W{ACTIVE_LOW}};

   state_t           state, state_n;
   logic [SEL_W-1:0] idx_n;
   logic             active_n;
   logic             wrap_n;
   logic [OUT_W-1:0] out_n;
   logic             scan_on;
   logic             step;

   assign scan_on = en & (mode == MODE_SCAN);

   seq_decoder_dwell #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .run  (scan_on & ~sel_valid),
      .clr  (scan_on & sel_valid),
      .step (step)
   );

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      active_n = active;
      wrap_n   = 1'b0;
      if (!en) begin
         state_n  = IDLE;
         active_n = 1'b0;
      end else if (mode == MODE_DIRECT) begin
         state_n = DIRECT;
         if (sel_valid) begin
            idx_n    = sel;
            active_n = 1'b1;
         end
      end else begin
         state_n  = SCAN;
         active_n = 1'b1;
         // a load on the dwell boundary beats the step
         if (sel_valid) begin
            idx_n = sel;
         end else if (step) begin
            if (!dir) begin
               idx_n  = idx + SEL_W'(1);
               wrap_n = (idx == '1);
            end else begin
               idx_n  = idx - SEL_W'(1);
               wrap_n = (idx == '0);
            end
         end
      end
      out_n = active_n ? OUT_W'(onehot(6'(idx_n), OUT_W)) : '0;
      out_n = out_n ^ POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         active <= 1'b0;
         wrap   <= 1'b0;
         out    <= POL;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         active <= active_n;
         wrap   <= wrap_n;
         out    <= out_n;
      end
   end

endmodule
